jelly_pulse_async_arbiter: RTL

- Multiplexes N independent single-cycle event pulses from the s_clk domain onto one toggle-handshake clock-domain crossing.
- Delivers each event to the m_clk domain as a one-cycle m_pulse tagged with its source channel in m_id.
- Per-channel pending counters absorb bursts that the crossing cannot take back-to-back, so events are queued rather than dropped.
- Used wherever several status or interrupt events must cross to a common destination clock through one shared synchronizer.

---
 rtl/jelly_pulse_async_arbiter_if.sv | 21 ++
 rtl/jelly_pulse_async_arbiter.sv | 117 +++++++++++
 2 files changed

// File: rtl/jelly_pulse_async_arbiter_if.sv
// jelly_pulse_async_arbiter_if: event inputs, status outputs and destination strobe of the pulse arbiter
interface jelly_pulse_async_arbiter_if #(
  parameter int N = 4,
  parameter int ID_WIDTH = 2
);
  logic [N-1:0] s_pulse;
  logic [N-1:0] s_overflow_clear;
  logic [N-1:0] s_pending;
  logic [N-1:0] s_overflow;
  logic s_busy;
  logic m_pulse;
  logic [ID_WIDTH-1:0] m_id;
  modport master (
    output s_pulse, s_overflow_clear,
    input s_pending, s_overflow, s_busy, m_pulse, m_id
  );
  modport slave (
    input s_pulse, s_overflow_clear,
    output s_pending, s_overflow, s_busy, m_pulse, m_id
  );
endinterface

// File: rtl/jelly_pulse_async_arbiter.sv
// jelly_pulse_async_arbiter: queues N event pulses per channel and ships them one at a time over a toggle-handshake CDC; define JELLY_PULSE_ASYNC_ARBITER_PRIORITY_EN for fixed-priority grants instead of round-robin
module jelly_pulse_async_arbiter #(
  parameter int N = 4,
  parameter int ID_WIDTH = 2,
  parameter int COUNTER_WIDTH = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic s_clk,
  input logic s_reset,
  input logic m_clk,
  input logic m_reset,
  jelly_pulse_async_arbiter_if.slave bus
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state;
  logic [COUNTER_WIDTH-1:0] cnt [N];
  logic [N-1:0] nz;
  logic [N-1:0] inc;
  logic [N-1:0] dec;
  logic [N-1:0] ovf;
  logic [ID_WIDTH-1:0] sel;
  logic [ID_WIDTH-1:0] id_reg;
  logic [ID_WIDTH:0] idx;
  logic found;
  logic grant;
  logic req_tgl;
  logic ack_tgl;
  logic m_pulse_r;
  logic [ID_WIDTH-1:0] m_id_r;
  (* ASYNC_REG = "true" *) logic [SYNC_STAGES-1:0] req_sync;
  (* ASYNC_REG = "true" *) logic [SYNC_STAGES-1:0] ack_sync;
`ifndef JELLY_PULSE_ASYNC_ARBITER_PRIORITY_EN
  logic [ID_WIDTH-1:0] last;
`endif
  assign bus.s_pending = nz;
  assign bus.s_overflow = ovf;
  assign bus.s_busy = state != IDLE;
  assign bus.m_pulse = m_pulse_r;
  assign bus.m_id = m_id_r;
  assign grant = state == IDLE && found;
  // channels with queued events
  always_comb begin
    for (int i = 0; i < N; i++) nz[i] = cnt[i] != '0;
  end
  // choose the next channel to grant
  always_comb begin
    sel = '0;
    found = 1'b0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
`ifdef JELLY_PULSE_ASYNC_ARBITER_PRIORITY_EN
      idx = (ID_WIDTH+1)'(k);
`else
      idx = {1'b0, last} + (ID_WIDTH+1)'(k + 1);
      idx = idx >= (ID_WIDTH+1)'(N) ? idx - (ID_WIDTH+1)'(N) : idx;
`endif
      if (!found && nz[idx[ID_WIDTH-1:0]]) begin
        sel = idx[ID_WIDTH-1:0];
        found = 1'b1;
      end
    end
  end
  // a grant frees a slot, so a saturated counter still accepts an event in the grant cycle
  always_comb begin
    for (int i = 0; i < N; i++) begin
      dec[i] = grant && sel == ID_WIDTH'(i);
      inc[i] = bus.s_pulse[i] && (cnt[i] != '1 || dec[i]);
    end
  end
  // pending counters and sticky overflow flags; a new overflow wins over a clear
  always_ff @(posedge s_clk) begin
    for (int i = 0; i < N; i++) begin
      cnt[i] <= s_reset ? '0 : cnt[i] + COUNTER_WIDTH'(inc[i]) - COUNTER_WIDTH'(dec[i]);
      ovf[i] <= s_reset ? 1'b0 : (ovf[i] && !bus.s_overflow_clear[i]) || (bus.s_pulse[i] && !inc[i]);
    end
  end
  // grant FSM: one transfer in flight, id_reg held until the acknowledge toggle returns
  always_ff @(posedge s_clk) begin
    if (s_reset) begin
      state <= IDLE;
      id_reg <= '0;
      req_tgl <= 1'b0;
`ifndef JELLY_PULSE_ASYNC_ARBITER_PRIORITY_EN
      last <= ID_WIDTH'(N - 1);
`endif
    end else if (state == IDLE) begin
      if (found) begin
        state <= WAIT;
        id_reg <= sel;
        req_tgl <= !req_tgl;
`ifndef JELLY_PULSE_ASYNC_ARBITER_PRIORITY_EN
        last <= sel;
`endif
      end
    end else if (ack_sync[SYNC_STAGES-1] == req_tgl) begin
      state <= IDLE;
    end
  end
  // acknowledge toggle back into the source domain
  always_ff @(posedge s_clk) begin
    ack_sync <= s_reset ? '0 : {ack_sync[SYNC_STAGES-2:0], ack_tgl};
  end
  // destination side: synchronize request, strobe once per toggle, echo it back as ack
  always_ff @(posedge m_clk) begin
    if (m_reset) begin
      req_sync <= '0;
      ack_tgl <= 1'b0;
      m_pulse_r <= 1'b0;
      m_id_r <= '0;
    end else begin
      req_sync <= {req_sync[SYNC_STAGES-2:0], req_tgl};
      ack_tgl <= req_sync[SYNC_STAGES-1];
      m_pulse_r <= req_sync[SYNC_STAGES-1] != ack_tgl;
      if (req_sync[SYNC_STAGES-1] != ack_tgl) m_id_r <= id_reg;
    end
  end
endmodule
